// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
// nibble_packer : gathers NIBBLES entries from an upstream FIFO into one word,
//                 with flush support for emitting a zero-padded partial word.
// Revision      : 1.0
// ============================================================================
module nibble_packer #(
  parameter int NIBBLE_W = 4,
  parameter int NIBBLES  = 4,
  parameter int OUT_W    = NIBBLE_W * NIBBLES
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                fifo_empty_i,
  output logic                fifo_ren_o,
  input  logic [NIBBLE_W-1:0] fifo_rdata_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_W-1:0]    out_data_o,
  output logic                out_last_o,
  output logic [7:0]          word_count_o
);

  localparam int               IDX_W    = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(NIBBLES);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rd_pending_q, rd_pending_d;
  logic             flush_req_q, flush_req_d;
  logic             out_last_q, out_last_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [7:0]       wc_q, wc_d;
  logic             started_q;
  logic [IDX_W-1:0] inflight;
  logic             ren;

  // started_q keeps the pop request low for the first cycle after reset release
  assign inflight = idx_q + IDX_W'(rd_pending_q);
  assign ren      = reset_ni && started_q && (state_q == COLLECT) && !fifo_empty_i
                    && (inflight < FULL_CNT) && !flush_req_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      rd_pending_q <= 1'b0;
      flush_req_q  <= 1'b0;
      out_last_q   <= 1'b0;
      data_q       <= '0;
      wc_q         <= 8'd0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_pending_q <= rd_pending_d;
      flush_req_q  <= flush_req_d;
      out_last_q   <= out_last_d;
      data_q       <= data_d;
      wc_q         <= wc_d;
      started_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_pending_d = ren;
    flush_req_d  = flush_req_q;
    out_last_d   = out_last_q;
    data_d       = data_q;
    wc_d         = wc_q;
    case (state_q)
      COLLECT: begin
        if (flush_i && ((idx_q != '0) || rd_pending_q)) begin
          flush_req_d = 1'b1;
        end
        if (rd_pending_q) begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              data_d[k*NIBBLE_W +: NIBBLE_W] = fifo_rdata_i;
            end
          end
          // A capture that completes the word wins over any pending flush
          if (idx_q == LAST_IDX) begin
            state_d     = OUTPUT;
            idx_d       = '0;
            out_last_d  = 1'b0;
            flush_req_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (flush_req_q) begin
          state_d     = OUTPUT;
          idx_d       = '0;
          out_last_d  = 1'b1;
          flush_req_d = 1'b0;
        end
      end
      OUTPUT: begin
        if (out_ready_i) begin
          state_d    = COLLECT;
          data_d     = '0;
          out_last_d = 1'b0;
          wc_d       = wc_q + 8'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign fifo_ren_o   = ren;
  assign out_valid_o  = (state_q == OUTPUT);
  assign out_data_o   = data_q;
  assign out_last_o   = out_last_q;
  assign word_count_o = wc_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// ============================================================================
// tb_nibble_packer : table-driven, directed and randomized checks of the packer
// Revision         : 1.0
// ============================================================================
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifo_empty;
  logic        fifo_ren;
  logic [3:0]  fifo_rdata = 4'h0;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [7:0]  word_count;

  always #5 clk = ~clk;

  nibble_packer #(.NIBBLE_W(4), .NIBBLES(4)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .fifo_empty_i(fifo_empty),
    .fifo_ren_o  (fifo_ren),
    .fifo_rdata_i(fifo_rdata),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .word_count_o(word_count)
  );

  // Upstream FIFO model: data appears the cycle after an accepted pop
  logic [3:0] fifo_mem [0:8191];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_ren && !fifo_empty) begin
      fifo_rdata <= fifo_mem[rd_ptr % 8192];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [15:0] d;
    bit          l;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [15:0] ents;
    int          n;
    bit          do_flush;
    logic [15:0] exp_data;
    bit          exp_last;
  } vec_t;
  vec_t tbl[8];

  int         errors = 0;
  int         checks = 0;
  int         viol   = 0;
  logic [7:0] mdl_wc = 8'd0;
  bit         rnd_ready = 1'b0;
  bit         held = 1'b0;
  logic [15:0] held_d;
  logic       held_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every handoff must match the next expected word
  always @(negedge clk) begin
    exp_t e;
    if (fifo_ren && fifo_empty) viol++;
    if (held && reset_n) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {16'd0, out_data}, {16'd0, held_d});
      chk("hold_last", {31'd0, out_last}, {31'd0, held_l});
    end
    held   = reset_n && out_valid && !out_ready;
    held_d = out_data;
    held_l = out_last;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h last %0b expected none at %0t",
                 out_data, out_last, $time);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", {16'd0, out_data}, {16'd0, e.d});
        chk("word_last", {31'd0, out_last}, {31'd0, e.l});
        mdl_wc = mdl_wc + 8'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [3:0] v);
    fifo_mem[wr_ptr % 8192] = v;
    wr_ptr++;
  endtask

  task automatic expect_word(input logic [15:0] d, input bit l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    exp_q.delete();
    mdl_wc = 8'd0;
    repeat (cycles) step();
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    logic [15:0] w;

    tbl[0] = '{16'h4321, 4, 1'b0, 16'h4321, 1'b0};
    tbl[1] = '{16'h00BA, 2, 1'b1, 16'h00BA, 1'b1};
    tbl[2] = '{16'h0005, 1, 1'b1, 16'h0005, 1'b1};
    tbl[3] = '{16'hFFFF, 4, 1'b0, 16'hFFFF, 1'b0};
    tbl[4] = '{16'h0CBA, 3, 1'b1, 16'h0CBA, 1'b1};
    tbl[5] = '{16'h0000, 4, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{16'h0E7D, 3, 1'b1, 16'h0E7D, 1'b1};
    tbl[7] = '{16'hA5C3, 4, 1'b0, 16'hA5C3, 1'b0};

    reset_n   = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    expect_word(16'h4321, 1'b0);
    step(); step();
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_wc", {24'd0, word_count}, 32'd0);
    chk("rst_ren", {31'd0, fifo_ren}, 32'd0);

    // Release, then measure first-word latency with a preloaded FIFO
    step();
    reset_n = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ren_first_cycle", {31'd0, fifo_ren}, 32'd0);
      if (n == 2) chk("ren_second_cycle", {31'd0, fifo_ren}, 32'd1);
      if (out_valid) break;
    end
    chk("first_word_latency", n, 32'd7);
    @(negedge clk);
    chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
    chk("wc_one", {24'd0, word_count}, 32'd1);

    // Backpressure: word held, no pops, flush in OUTPUT ignored
    step();
    out_ready = 1'b0;
    expect_word(16'h3210, 1'b0);
    expect_word(16'h7654, 1'b0);
    for (int i = 0; i < 8; i++) push(4'(i));
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("held_word_appears", {31'd0, out_valid}, 32'd1);
    base = rd_ptr;
    step();
    pulse_flush();
    step(); step(); step();
    @(negedge clk);
    chk("no_pop_while_held", rd_ptr - base, 32'd0);
    chk("still_valid", {31'd0, out_valid}, 32'd1);
    step();
    out_ready = 1'b1;
    wait_drain(40);
    repeat (8) step();
    chk("wc_three", {24'd0, word_count}, 32'd3);

    // Table of full and flushed words
    for (int i = 0; i < 8; i++) begin
      expect_word(tbl[i].exp_data, tbl[i].exp_last);
      for (int k = 0; k < tbl[i].n; k++) push(tbl[i].ents[k*4 +: 4]);
      if (tbl[i].do_flush) begin
        n = 0;
        while (rd_ptr != wr_ptr && n < 20) begin
          step();
          n++;
        end
        step(); step(); step();
        pulse_flush();
      end
      wait_drain(30);
      step(); step();
    end
    chk("wc_after_table", {24'd0, word_count}, {24'd0, mdl_wc});

    // Flush in the cycle the third entry is still pending
    expect_word(16'h0CBA, 1'b1);
    push(4'hA); push(4'hB); push(4'hC);
    step(); step(); step();
    pulse_flush();
    wait_drain(20);

    // Flush while the word-completing entry is pending: full word, no partial
    expect_word(16'hDCBA, 1'b0);
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    step(); step(); step(); step();
    pulse_flush();
    wait_drain(20);
    repeat (6) step();
    @(negedge clk);
    chk("no_partial_after_fill", {31'd0, out_valid}, 32'd0);

    // Flush with nothing collected is ignored
    step();
    pulse_flush();
    repeat (8) step();
    @(negedge clk);
    chk("flush_idle_ignored", {31'd0, out_valid}, 32'd0);

    // Reset after two captures: in-flight entry lost, rest starts a new word
    step();
    base = rd_ptr;
    push(4'h9); push(4'h8); push(4'h7); push(4'h6); push(4'h5);
    step(); step(); step();
    reset_n = 1'b0;
    exp_q.delete();
    mdl_wc = 8'd0;
    @(negedge clk);
    chk("ren_in_reset", {31'd0, fifo_ren}, 32'd0);
    step(); step();
    @(negedge clk);
    chk("mid_rst_data", {16'd0, out_data}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_wc", {24'd0, word_count}, 32'd0);
    chk("popped_before_reset", rd_ptr - base, 32'd3);
    step();
    reset_n = 1'b1;
    expect_word(16'hC356, 1'b0);
    repeat (10) step();
    @(negedge clk);
    chk("partial_waits", {31'd0, out_valid}, 32'd0);
    step();
    push(4'h3); push(4'hC);
    wait_drain(20);

    // Randomized words with random backpressure, checked up to the counter wrap
    do_reset(2);
    rnd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      expect_word(w, 1'b0);
      for (int k = 0; k < 4; k++) begin
        push(w[k*4 +: 4]);
        repeat ($urandom_range(0, 2)) step();
      end
      if (i == 254) begin
        wait_drain(4000);
        step(); step();
        chk("wc_255", {24'd0, word_count}, 32'd255);
        chk("wc_model_255", {24'd0, word_count}, {24'd0, mdl_wc});
      end
    end
    wait_drain(4000);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    step(); step();
    chk("wc_wrap", {24'd0, word_count}, 32'd0);

    chk("ren_while_empty", viol, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter NIBBLE_W, default 4, width of one FIFO entry.
REQ-002 Parameter NIBBLES, default 4, entries packed per output word; OUT_W = NIBBLE_W*NIBBLES.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low (0 = reset, sampled on rising clk).
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_ren  output  1  pop request to upstream FIFO.
REQ-007 fifo_rdata  input  NIBBLE_W  FIFO read data, valid the cycle after an accepted pop.
REQ-008 flush  input  1  single-cycle request to emit a partial word.
REQ-009 out_valid  output  1  out_data/out_last valid.
REQ-010 out_ready  input  1  downstream accepts when high with out_valid.
REQ-011 out_data  output  OUT_W  packed word.
REQ-012 out_last  output  1  word is a flushed partial word.
REQ-013 word_count  output  8  words handed off since reset.

Function
REQ-014 Two states: COLLECT, OUTPUT; reset enters COLLECT.
REQ-015 Pop accepted when fifo_ren=1 and fifo_empty=0 at a clk edge; fifo_ren never asserted while fifo_empty=1.
REQ-016 rd_pending register = 1 in the cycle after an accepted pop; fifo_rdata captured at the end of that cycle.
REQ-017 fifo_ren = COLLECT && !fifo_empty && (idx + rd_pending) < NIBBLES && !flush_req; back-to-back pops allowed (one per cycle).
REQ-018 Captured entry k (k = 0 first popped) placed at out_data bits [k*NIBBLE_W +: NIBBLE_W]; idx increments per capture.
REQ-019 When idx reaches NIBBLES on a capture: next state OUTPUT, out_valid=1, out_last=0, idx cleared.
REQ-020 OUTPUT: fifo_ren=0; out_data, out_last held stable until out_valid && out_ready.
REQ-021 Handshake in OUTPUT: out_valid drops next cycle, state returns to COLLECT, word_count increments, wraps 255 -> 0.
REQ-022 Latency: full word out_valid rises one cycle after the final capture cycle; max sustained rate one word per NIBBLES+2 cycles.
REQ-023 flush in COLLECT with idx>0 or rd_pending=1 sets flush_req; flush with idx=0 and rd_pending=0 ignored.
REQ-024 flush_req with rd_pending=0: next state OUTPUT, out_last=1, unfilled slots zero, idx cleared, flush_req cleared.
REQ-025 flush_req with rd_pending=1: pending capture completes first, then REQ-024 applies; if that capture fills the word, out_last=0, flush_req cleared.
REQ-026 flush in OUTPUT ignored.
REQ-027 Upstream empty mid-word: packer waits indefinitely in COLLECT, partial data retained.

Reset
REQ-028 reset=0: state COLLECT, idx=0, rd_pending=0, flush_req=0, fifo_ren=0, out_valid=0, out_last=0, out_data=0, word_count=0.
REQ-029 Reset mid-word or mid-OUTPUT discards partial/held data; an entry popped in the reset cycle is lost.
REQ-030 fifo_ren=0 during and in the first cycle after reset release.

Verification
REQ-031 FIFO preloaded 1,2,3,4, out_ready=1 -> out_data=0x4321, out_last=0, one cycle valid, word_count=1.
REQ-032 Preload 8 entries 0..7, out_ready=0 for 5 cycles -> 0x3210 held stable, no pops while held; after ready, second word 0x7654, word_count=2.
REQ-033 Preload A,B then flush -> out_data=0x00BA, out_last=1; flush with idx=0 -> no output.
REQ-034 Flush asserted in the cycle rd_pending=1 for 3rd entry C (A,B captured) -> out_data=0x0CBA, out_last=1.
REQ-035 Preload 5 entries, assert reset after 2 captures -> all outputs 0; after release, remaining entries form next word from slot 0.
REQ-036 256 full-word handshakes -> word_count wraps to 0; fifo_ren never high while fifo_empty=1 (assertion throughout).
